// File: rtl/mppt_particle_sched.sv
// Particle scheduler for MPPT fitness evaluation. For each particle it loads a duty,
// waits for the converter to settle, averages ADC samples, reports u*i and tracks the best.
module mppt_particle_sched #(
  parameter int N_PART   = 5,
  parameter int DW       = 12,
  parameter int SETTLE   = 1000,
  parameter int AVG_LOG2 = 4
) (
  input  logic          clk_P,
  input  logic          rst_n,
  input  logic          start,
  input  logic          duty_we,
  input  logic [2:0]    duty_waddr,
  input  logic [DW-1:0] duty_wdata,
  input  logic          ad_valid,
  input  logic [11:0]   ad_u,
  input  logic [11:0]   ad_i,
  output logic [DW-1:0] pwm_duty,
  output logic          pwm_load,
  output logic          fit_valid,
  output logic [2:0]    fit_addr,
  output logic [23:0]   fit_p,
  output logic [2:0]    gbest_addr,
  output logic [23:0]   gbest_p,
  output logic          busy,
  output logic          done
);
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [NCW-1:0] SMP_LAST    = NCW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]     K_LAST      = 3'(N_PART - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_CALC, S_REPORT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic [SCW-1:0]          settle_q, settle_d;
  logic [NCW-1:0]          smp_q, smp_d;
  logic [15:0]             acc_u_q, acc_u_d;
  logic [15:0]             acc_i_q, acc_i_d;
  logic [23:0]             p_q, p_d;
  logic [2:0]              fit_addr_q, fit_addr_d;
  logic [2:0]              gbest_addr_q, gbest_addr_d;
  logic [23:0]             gbest_p_q, gbest_p_d;
  logic [DW-1:0]           pwm_duty_q, pwm_duty_d;
  logic [11:0]             u_avg, i_avg;
  logic [N_PART-1:0][DW-1:0] duty_tab;

  // One register per duty entry; out-of-range addresses match no entry.
  generate
    for (genvar gi = 0; gi < N_PART; gi++) begin : g_duty
      logic [DW-1:0] entry_q;
      always_ff @(posedge clk_P) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else if (duty_we && (duty_waddr == 3'(gi))) begin
          entry_q <= duty_wdata;
        end
      end
      assign duty_tab[gi] = entry_q;
    end
  endgenerate

  // Averages are a bit-slice of the accumulators: truncating divide by 2^AVG_LOG2.
  assign u_avg = acc_u_q[AVG_LOG2 +: 12];
  assign i_avg = acc_i_q[AVG_LOG2 +: 12];

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    settle_d     = settle_q;
    smp_d        = smp_q;
    acc_u_d      = acc_u_q;
    acc_i_d      = acc_i_q;
    p_d          = p_q;
    fit_addr_d   = fit_addr_q;
    gbest_addr_d = gbest_addr_q;
    gbest_p_d    = gbest_p_q;
    pwm_duty_d   = pwm_duty_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          gbest_addr_d = '0;
          gbest_p_d    = '0;
          k_d          = '0;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_d = '0;
        smp_d    = '0;
        acc_u_d  = '0;
        acc_i_d  = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      S_SAMPLE: begin
        if (ad_valid) begin
          acc_u_d = acc_u_q + {4'b0, ad_u};
          acc_i_d = acc_i_q + {4'b0, ad_i};
          if (smp_q == SMP_LAST) begin
            state_d = S_CALC;
          end else begin
            smp_d = smp_q + NCW'(1);
          end
        end
      end
      S_CALC: begin
        p_d        = 24'(u_avg) * 24'(i_avg);
        fit_addr_d = k_q + 3'd1;
        state_d    = S_REPORT;
      end
      S_REPORT: begin
        // Strict compare so a tie keeps the earlier particle.
        if ((p_q > gbest_p_q) || (gbest_addr_q == 3'd0)) begin
          gbest_p_d    = p_q;
          gbest_addr_d = fit_addr_q;
        end
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Duty is registered on entry so it is already stable during the pwm_load cycle.
    if (state_d == S_APPLY) begin
      for (int j = 0; j < N_PART; j++) begin
        if (k_d == 3'(j)) begin
          pwm_duty_d = duty_tab[j];
        end
      end
    end
  end

  always_ff @(posedge clk_P) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      settle_q     <= '0;
      smp_q        <= '0;
      acc_u_q      <= '0;
      acc_i_q      <= '0;
      p_q          <= '0;
      fit_addr_q   <= '0;
      gbest_addr_q <= '0;
      gbest_p_q    <= '0;
      pwm_duty_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      settle_q     <= settle_d;
      smp_q        <= smp_d;
      acc_u_q      <= acc_u_d;
      acc_i_q      <= acc_i_d;
      p_q          <= p_d;
      fit_addr_q   <= fit_addr_d;
      gbest_addr_q <= gbest_addr_d;
      gbest_p_q    <= gbest_p_d;
      pwm_duty_q   <= pwm_duty_d;
    end
  end

  assign pwm_duty   = pwm_duty_q;
  assign pwm_load   = (state_q == S_APPLY);
  assign fit_valid  = (state_q == S_REPORT);
  assign fit_addr   = fit_addr_q;
  assign fit_p      = p_q;
  assign gbest_addr = gbest_addr_q;
  assign gbest_p    = gbest_p_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mppt_particle_sched.sv
// Bench for mppt_particle_sched: a schedule model plans stimulus and predicts every
// output pulse, duty, power and global best per run; table rows add fixed expectations.
module tb_mppt_particle_sched;
  localparam int N_PART   = 5;
  localparam int DW       = 12;
  localparam int SETTLE   = 4;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int MAXR     = 512;

  logic          clk_P = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          duty_we = 1'b0;
  logic [2:0]    duty_waddr = '0;
  logic [DW-1:0] duty_wdata = '0;
  logic          ad_valid = 1'b0;
  logic [11:0]   ad_u = '0;
  logic [11:0]   ad_i = '0;
  logic [DW-1:0] pwm_duty;
  logic          pwm_load, fit_valid, busy, done;
  logic [2:0]    fit_addr, gbest_addr;
  logic [23:0]   fit_p, gbest_p;

  int checks = 0;
  int failures = 0;

  always #5 clk_P = ~clk_P;

  mppt_particle_sched #(
    .N_PART(N_PART), .DW(DW), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk_P(clk_P), .rst_n(rst_n), .start(start),
    .duty_we(duty_we), .duty_waddr(duty_waddr), .duty_wdata(duty_wdata),
    .ad_valid(ad_valid), .ad_u(ad_u), .ad_i(ad_i),
    .pwm_duty(pwm_duty), .pwm_load(pwm_load),
    .fit_valid(fit_valid), .fit_addr(fit_addr), .fit_p(fit_p),
    .gbest_addr(gbest_addr), .gbest_p(gbest_p),
    .busy(busy), .done(done)
  );

  // Model state: duty table contents and the last duty handed to the PWM.
  int mtab[N_PART];
  int last_duty = 0;

  // Per-cycle stimulus plan and predictions, indexed by cycle relative to start.
  bit       vld_a[MAXR];
  int       u_a[MAXR];
  int       i_a[MAXR];
  bit       st_a[MAXR];
  bit       we_a[MAXR];
  int       wa_a[MAXR];
  int       wd_a[MAXR];
  bit [3:0] ef_a[MAXR];   // {pwm_load, fit_valid, done, busy}
  int       ed_a[MAXR];
  int       efa_a[MAXR];
  longint   efp_a[MAXR];

  typedef struct {
    int     mode;
    int     cu;
    int     ci;
    longint exp_p;
    int     exp_ga;
    longint exp_gp;
  } run_vec_t;

  run_vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int peak_i(input int d);
    int x;
    x = d - 300;
    if (x < 0) x = -x;
    x = 4000 - x * 8;
    return (x < 0) ? 0 : x;
  endfunction

  task automatic wr_duty(input int a, input int d);
    @(negedge clk_P);
    duty_we    = 1'b1;
    duty_waddr = 3'(a);
    duty_wdata = DW'(d);
    @(posedge clk_P);
    #1;
    duty_we = 1'b0;
    if (a < N_PART) mtab[a] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwm_duty"}, pwm_duty, 0);
    chk({tag, "_flags"}, {pwm_load, fit_valid, done, busy}, 0);
    chk({tag, "_fit_addr"}, fit_addr, 0);
    chk({tag, "_fit_p"}, fit_p, 0);
    chk({tag, "_gbest_addr"}, gbest_addr, 0);
    chk({tag, "_gbest_p"}, gbest_p, 0);
  endtask

  // mode: 0 constant u/i, 1 peak plant, 2 averaging pattern, 3 sparse strobes, 4 random strobes
  task automatic do_run(input int mode, input int cu, input int ci, input bit corner,
                        input longint tbl_p, input int tbl_ga, input longint tbl_gp);
    int     r, dr, n, o, su, si, gaddr, wr_next, pd;
    longint p, gp;
    pd = last_duty;
    for (int j = 0; j < MAXR; j++) begin
      vld_a[j] = 1'($urandom);
      u_a[j]   = $urandom_range(0, 4095);
      i_a[j]   = $urandom_range(0, 4095);
      st_a[j]  = 1'b0;
      we_a[j]  = 1'b0;
      wa_a[j]  = 0;
      wd_a[j]  = 0;
      ef_a[j]  = '0;
      ed_a[j]  = 0;
      efa_a[j] = 0;
      efp_a[j] = 0;
    end
    st_a[0] = 1'b1;
    if (corner) begin
      st_a[20] = 1'b1;
      we_a[25] = 1'b1; wa_a[25] = 4; wd_a[25] = 777;
      we_a[26] = 1'b1; wa_a[26] = 0; wd_a[26] = 999;
    end
    r = 1; gaddr = 0; gp = 0; wr_next = 0;
    for (int k = 0; k < N_PART; k++) begin
      // Table writes landing before the duty is captured for this particle count.
      while (wr_next < r - 1) begin
        if (we_a[wr_next] && wa_a[wr_next] < N_PART) mtab[wa_a[wr_next]] = wd_a[wr_next];
        wr_next++;
      end
      ef_a[r][3] = 1'b1;
      ed_a[r]    = mtab[k];
      last_duty  = mtab[k];
      r = r + 1 + SETTLE;
      o = 0; n = 0; su = 0; si = 0;
      while (n < NS) begin
        case (mode)
          0: begin vld_a[r] = 1'b1; u_a[r] = cu; i_a[r] = ci; end
          1: begin vld_a[r] = 1'b1; u_a[r] = 2000; i_a[r] = peak_i(mtab[k]); end
          2: begin vld_a[r] = 1'b1; u_a[r] = (n == 0) ? 10 : 11; i_a[r] = 4095; end
          3: vld_a[r] = ((o % 7) == 6);
          default: if (o > 40) vld_a[r] = 1'b1;
        endcase
        if (vld_a[r]) begin
          su += u_a[r];
          si += i_a[r];
          n++;
        end
        r++;
        o++;
      end
      p = longint'(su >> AVG_LOG2) * longint'(si >> AVG_LOG2);
      ef_a[r + 1][2] = 1'b1;
      efa_a[r + 1]   = k + 1;
      efp_a[r + 1]   = p;
      if (p > gp || gaddr == 0) begin
        gp    = p;
        gaddr = k + 1;
      end
      r += 2;
    end
    dr = r;
    ef_a[dr][1] = 1'b1;
    for (int j = 1; j <= dr; j++) ef_a[j][0] = 1'b1;
    while (wr_next <= dr) begin
      if (we_a[wr_next] && wa_a[wr_next] < N_PART) mtab[wa_a[wr_next]] = wd_a[wr_next];
      wr_next++;
    end
    if (corner) st_a[dr] = 1'b1;

    for (int c = 0; c <= dr; c++) begin
      @(negedge clk_P);
      start      = st_a[c];
      ad_valid   = vld_a[c];
      ad_u       = 12'(u_a[c]);
      ad_i       = 12'(i_a[c]);
      duty_we    = we_a[c];
      duty_waddr = 3'(wa_a[c]);
      duty_wdata = DW'(wd_a[c]);
      chk("flags", {pwm_load, fit_valid, done, busy}, ef_a[c]);
      if (c == 0) chk("duty_hold", pwm_duty, pd);
      if (c == 1) begin
        chk("gbest_clr_addr", gbest_addr, 0);
        chk("gbest_clr_p", gbest_p, 0);
      end
      if (ef_a[c][3]) chk("pwm_duty", pwm_duty, ed_a[c]);
      if (ef_a[c][2]) begin
        chk("fit_addr", fit_addr, efa_a[c]);
        chk("fit_p", fit_p, efp_a[c]);
        if (tbl_p >= 0) chk("tbl_fit_p", fit_p, tbl_p);
      end
      if (c == dr) begin
        chk("gbest_addr", gbest_addr, gaddr);
        chk("gbest_p", gbest_p, gp);
        if (tbl_ga >= 0) chk("tbl_gbest_addr", gbest_addr, tbl_ga);
        if (tbl_gp >= 0) chk("tbl_gbest_p", gbest_p, tbl_gp);
      end
    end
    @(posedge clk_P);
    #1;
    start    = 1'b0;
    duty_we  = 1'b0;
    ad_valid = 1'b0;
    $display("run mode=%0d cycles=%0d gbest_addr=%0d gbest_p=%0d", mode, dr + 1, gaddr, gp);
  endtask

  initial begin
    vecs[0] = '{mode: 0, cu: 100,  ci: 50,   exp_p: 5000,     exp_ga: 1, exp_gp: 5000};
    vecs[1] = '{mode: 0, cu: 4095, ci: 4095, exp_p: 16769025, exp_ga: 1, exp_gp: 16769025};
    vecs[2] = '{mode: 1, cu: 0,    ci: 0,    exp_p: -1,       exp_ga: 3, exp_gp: 8000000};
    vecs[3] = '{mode: 2, cu: 0,    ci: 0,    exp_p: 40950,    exp_ga: 1, exp_gp: 40950};
    vecs[4] = '{mode: 0, cu: 0,    ci: 0,    exp_p: 0,        exp_ga: 1, exp_gp: 0};
    for (int a = 0; a < N_PART; a++) mtab[a] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk_P);
    #1;
    chk_zero("por");
    rst_n = 1'b1;

    for (int a = 0; a < N_PART; a++) wr_duty(a, (a + 1) * 100);
    for (int v = 0; v < 5; v++) begin
      do_run(vecs[v].mode, vecs[v].cu, vecs[v].ci, 1'b0,
             vecs[v].exp_p, vecs[v].exp_ga, vecs[v].exp_gp);
    end

    // Out-of-range write, busy start, mid-run rewrites of entries 4 and 0.
    wr_duty(6, 1234);
    do_run(0, 100, 50, 1'b1, 5000, 1, 5000);
    do_run(0, 7, 9, 1'b0, 63, 1, 63);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 1) begin
        for (int a = 0; a < N_PART; a++) wr_duty(a, $urandom_range(0, 4095));
      end
      do_run(3 + (t % 2), 0, 0, 1'b0, -1, -1, -1);
    end

    // Reset held for three cycles while waiting in SAMPLE.
    @(negedge clk_P);
    start = 1'b1;
    ad_valid = 1'b0;
    @(posedge clk_P);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk_P);
    #1;
    chk("rst_pre_busy", busy, 1);
    @(negedge clk_P);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk_P);
      #1;
      chk_zero("rst");
    end
    @(negedge clk_P);
    rst_n = 1'b1;
    for (int a = 0; a < N_PART; a++) mtab[a] = 0;
    last_duty = 0;
    do_run(0, 100, 50, 1'b0, 5000, 1, 5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mppt_particle_sched.md
Name: mppt_particle_sched

Overview:
- Sequencer for the MPPT fitness-evaluation datapath.
- On each run it steps through N_PART candidate duty cycles (particles). For each particle it:
  - loads the duty into the PWM generator,
  - waits for the converter to settle,
  - averages 2^AVG_LOG2 voltage/current ADC samples,
  - computes power p = u*i,
  - reports p with the 1-based particle address.
- Tracks the global-best particle across the run for the optimiser above it.

Parameters:
- N_PART, 5: particles per run (1..7).
- DW, 12: PWM duty width.
- SETTLE, 1000: settle cycles after each duty load (>=1).
- AVG_LOG2, 4: log2 of ADC samples averaged per particle (0..4).

Ports:
- clk_P  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run (sampled in IDLE only)
- duty_we  in  1  duty table write strobe
- duty_waddr  in  3  duty table index, 0-based
- duty_wdata  in  DW  duty value
- ad_valid  in  1  ADC sample strobe (ad_u/ad_i valid)
- ad_u  in  12  voltage sample, unsigned
- ad_i  in  12  current sample, unsigned
- pwm_duty  out  DW  duty to PWM generator
- pwm_load  out  1  one-cycle pulse: PWM latches pwm_duty
- fit_valid  out  1  one-cycle pulse: fit_addr/fit_p valid
- fit_addr  out  3  particle address, 1..N_PART
- fit_p  out  24  particle power
- gbest_addr  out  3  address of best particle this run (0 = none)
- gbest_p  out  24  best power this run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst_n low at a clk_P edge):
  - All outputs go to 0; duty table entries go to 0; FSM goes to IDLE; particle index k=0; all counters and accumulators are cleared.
  - Applies mid-run: the run is abandoned with no fit_valid or done pulse.
- Duty table:
  - N_PART x DW registers, written on duty_we in any state.
  - duty_waddr >= N_PART: write is ignored.
  - A write to entry k after APPLY(k) affects only the next run.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, CALC, REPORT, DONE.
  - IDLE: if start=1, clear gbest_addr/gbest_p to 0, set k=0, go to APPLY. start is ignored in every other state.
  - APPLY (1 cycle): register pwm_duty<=duty[k] and pwm_load=1 for this cycle only; clear settle counter; go to SETTLE.
  - SETTLE: count clk_P cycles; after exactly SETTLE cycles in SETTLE, go to SAMPLE. ad_valid is ignored here.
  - SAMPLE: on each ad_valid, acc_u+=ad_u, acc_i+=ad_i (16-bit accumulators, no overflow possible). After the 2^AVG_LOG2-th accepted sample, go to CALC. Waits indefinitely if ad_valid never arrives.
  - CALC (1 cycle): u=acc_u>>AVG_LOG2 and i=acc_i>>AVG_LOG2 (truncate, 12 bit each); p_reg<=u*i (24-bit unsigned, exact); go to REPORT.
  - REPORT (1 cycle): fit_valid=1, fit_addr=k+1, fit_p=p_reg. fit_addr/fit_p hold their values until the next REPORT.
    - If p_reg > gbest_p (strict) or gbest_addr==0: gbest_p<=p_reg, gbest_addr<=k+1. A tie keeps the earlier particle.
    - If k==N_PART-1, go to DONE; else k<=k+1 and go to APPLY.
  - DONE (1 cycle): done=1; go to IDLE. gbest_* hold until the next start or reset.
- Latency per particle: 1 (APPLY) + SETTLE + sample wait + 1 (CALC) + 1 (REPORT) cycles.
  - With ad_valid tied high: SETTLE + 2^AVG_LOG2 + 3.
- pwm_duty holds its last value between runs.
- start asserted in the same cycle as DONE is ignored; start on the first IDLE cycle is accepted.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-run (in SAMPLE) -> next cycle all outputs 0, busy=0, no fit_valid/done; a following start runs cleanly from k=0.
- Constant input: SETTLE=4, AVG_LOG2=2, ad_valid=1, ad_u=100, ad_i=50, duty={100,200,300,400,500} -> five pwm_load pulses carrying 100..500; fit_p=5000 for addresses 1..5; each particle 11 cycles apart; gbest_addr=1 (ties keep first); done one cycle after the 5th fit_valid.
- Peak search: bench model ad_i = 4000 - |duty-300|*8, ad_u=2000 -> fit_p for addr3 = 8,000,000, the maximum; gbest_addr=3, gbest_p=8000000.
- Averaging/truncation: AVG_LOG2=2, ad_u samples 10,11,11,11 (sum 43 -> u=10), ad_i=4095 x4 -> fit_p=40950. Max case: ad_u=ad_i=4095 -> fit_p=16769025, no overflow.
- Sparse ad_valid: ad_valid every 7th cycle during SAMPLE -> exactly 2^AVG_LOG2 samples accepted; CALC occurs one cycle after the last accepted strobe.
- Control corners: start pulsed while busy -> ignored, no restart. duty_we with waddr=6 -> table unchanged. duty[4] rewritten during particle 2 -> new value used in this run. duty[0] rewritten during particle 2 -> new value appears only on the next run.
